// File: rtl/bcd_down_counter_if.sv
// Control and status bundle for bcd_down_counter.
// The master side drives the commands; the slave side is the counter.
interface bcd_down_counter_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    localparam int unsigned W = 4 * NUM_DIGITS;

    logic         tick;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output tick, load, load_val, start, pause,
        input  count, busy, done, err
    );

    modport slave (
        input  tick, load, load_val, start, pause,
        output count, busy, done, err
    );
endinterface

// File: rtl/bcd_down_counter.sv
// BCD down counter with IDLE/RUN/PAUSED/EXPIRED control.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload the last valid
// load value and keep running instead of stopping in EXPIRED.
module bcd_down_counter #(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    bcd_down_counter_if.slave bus
);
    localparam int unsigned W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t       state_q;
    logic [W-1:0] count_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0] reload_q;
`endif

    // Subtract one in BCD: each digit at 0 wraps to 9 and borrows onward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every digit is in 0..9.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [W-1:0] count_d;
    logic         load_ok;

    // Decremented value and load validity for the current cycle.
    always_comb begin
        count_d = bcd_dec(count_q);
        load_ok = bcd_valid(bus.load_val);
    end

    // Control FSM; priority is load > pause > start > tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    count_q  <= bus.load_val;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    err_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_q <= bus.load_val;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && (count_q != '0)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state_q <= PAUSED;
                        end else if (bus.tick && (count_q != '0)) begin
                            if (count_d == '0) begin
                                done_q  <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                count_q <= reload_q;
`else
                                count_q <= '0;
                                state_q <= EXPIRED;
                                busy_q  <= 1'b0;
`endif
                            end else begin
                                count_q <= count_d;
                            end
                        end
                    end
                    PAUSED: begin
                        if (bus.start) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        // EXPIRED waits for a valid load.
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed scenarios followed by
// random commands, all compared against a decimal-arithmetic model.
module tb_bcd_down_counter;
    localparam int unsigned ND = 2;
    localparam int unsigned W  = 4 * ND;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    bcd_down_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_down_counter #(.NUM_DIGITS(ND)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer value plus a mode.
    typedef enum int { M_IDLE, M_RUNNING, M_HELD, M_STOPPED } mode_t;
    mode_t m_mode;
    int    m_val;
    int    m_reload;
    bit    m_done;
    bit    m_err;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int r;
        int s;
        r = 0;
        s = 1;
        for (int i = 0; i < ND; i++) begin
            r = r + int'(v[4*i +: 4]) * s;
            s = s * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_val    = 0;
        m_reload = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit ld, input logic [W-1:0] lv,
                              input bit st, input bit pa);
        m_done = 1'b0;
        if (ld) begin
            if (is_bcd(lv)) begin
                m_val    = from_bcd(lv);
                m_reload = m_val;
                m_mode   = M_IDLE;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_mode == M_RUNNING) begin
            if (pa) begin
                m_mode = M_HELD;
            end else if (tk && m_val > 0) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    m_val = m_reload;
`else
                    m_mode = M_STOPPED;
`endif
                end
            end
        end else if (m_mode == M_IDLE) begin
            if (st && m_val != 0) m_mode = M_RUNNING;
        end else if (m_mode == M_HELD) begin
            if (st) m_mode = M_RUNNING;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(to_bcd(m_val)));
        chk({tag, "_busy"},  32'(bus.busy),  32'(m_mode == M_RUNNING || m_mode == M_HELD));
        chk({tag, "_done"},  32'(bus.done),  32'(m_done));
        chk({tag, "_err"},   32'(bus.err),   32'(m_err));
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic step(input string tag, input bit tk, input bit ld, input logic [W-1:0] lv,
                        input bit st, input bit pa);
        @(negedge clk);
        bus.tick     = tk;
        bus.load     = ld;
        bus.load_val = lv;
        bus.start    = st;
        bus.pause    = pa;
        model_step(tk, ld, lv, st, pa);
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),  32'd0);
        chk({tag, "_done"},  32'(bus.done),  32'd0);
        chk({tag, "_err"},   32'(bus.err),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [W-1:0] lv;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.tick = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.start = 1'b0; bus.pause = 1'b0;
        model_reset();
        #12;
        chk_model("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Load 03, start, tick to expiry.
        step("l03",   0, 1, 8'h03, 0, 0);
        step("st03",  0, 0, 8'h00, 1, 0);
        chk("st03_busy_c", 32'(bus.busy), 32'd1);
        step("t02",   1, 0, 8'h00, 0, 0);
        step("t01",   1, 0, 8'h00, 0, 0);
        step("t00",   1, 0, 8'h00, 0, 0);
        chk("t00_done_c", 32'(bus.done), 32'd1);
        step("post0", 1, 0, 8'h00, 1, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk("post0_busy_c", 32'(bus.busy), 32'd0);
        chk("post0_cnt_c",  32'(bus.count), 32'h00);
`endif

        // Borrow 10 -> 09; start from zero stays idle.
        step("l10",   0, 1, 8'h10, 0, 0);
        step("st10",  0, 0, 8'h00, 1, 0);
        step("t09",   1, 0, 8'h00, 0, 0);
        chk("t09_cnt_c", 32'(bus.count), 32'h09);
        step("l00",   0, 1, 8'h00, 0, 0);
        step("st00",  0, 0, 8'h00, 1, 0);
        step("tk00",  1, 0, 8'h00, 1, 0);
        chk("st00_busy_c", 32'(bus.busy), 32'd0);

        // Pause wins over a coincident tick; ticks ignored while paused.
        step("l05",   0, 1, 8'h05, 0, 0);
        step("st05",  0, 0, 8'h00, 1, 0);
        step("pt05",  1, 0, 8'h00, 0, 1);
        chk("pt05_cnt_c", 32'(bus.count), 32'h05);
        step("pz1",   1, 0, 8'h00, 0, 0);
        step("pz2",   1, 0, 8'h00, 0, 0);
        step("res",   0, 0, 8'h00, 1, 0);
        step("t04",   1, 0, 8'h00, 0, 0);
        chk("t04_cnt_c", 32'(bus.count), 32'h04);

        // Invalid load sets sticky err; valid load clears it.
        step("l3a",   0, 1, 8'h3A, 0, 0);
        chk("l3a_err_c", 32'(bus.err), 32'd1);
        step("hold",  1, 0, 8'h00, 0, 0);
        step("l07",   0, 1, 8'h07, 0, 0);
        chk("l07_err_c", 32'(bus.err), 32'd0);

        // Asynchronous reset mid-run.
        step("l02",   0, 1, 8'h02, 0, 0);
        step("st02",  0, 0, 8'h00, 1, 0);
        step("t01r",  1, 0, 8'h00, 0, 0);
        async_reset("arst");
        step("arst1", 1, 0, 8'h00, 1, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto reload: 02 -> 01 -> 02 -> 01 ...
        step("ar_l",  0, 1, 8'h02, 0, 0);
        step("ar_s",  0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) step("ar_t", 1, 0, 8'h00, 0, 0);
        chk("ar_busy_c", 32'(bus.busy), 32'd1);
`endif

        // Random commands against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) lv = W'($urandom);
            else lv = to_bcd(int'($urandom_range(0, 99)));
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk);
                #2;
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 9) < 6,
                     $urandom_range(0, 24) == 0,
                     lv,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 11) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
